// File: rtl/ram_master.sv
// Burst master for a single-port RAM with a shared tristate data bus.
// Latency: writes take one cycle per accepted beat, reads two cycles per beat, plus one FINISH cycle.
// Backpressure: wr_valid low stalls the write burst; rd_valid has no backpressure; cmd_ready only in IDLE.
module ram_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] Address,
    inout  wire  [DATA_W-1:0] Data,
    output logic              RW,
    output logic              En
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_ISSUE,
        READ_WAIT,
        FINISH
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [LEN_W:0]    beats;
    logic [DATA_W-1:0] wr_q;
    logic              last_beat;

    assign cmd_ready = (state == IDLE) && !rst;
    assign wr_ready  = (state == WRITE) && !rst;
    assign busy      = (state != IDLE);
    assign last_beat = (beats == (LEN_W+1)'(1));

    // The bus is only ever driven from registered En/RW, so a read cycle can never overlap a drive.
    assign Data = (En && RW) ? wr_q : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_cnt <= '0;
            beats    <= '0;
            wr_q     <= '0;
            Address  <= '0;
            RW       <= 1'b0;
            En       <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        beats <= (LEN_W+1)'(cmd_len) + (LEN_W+1)'(1);
                        if (cmd_write) begin
                            state    <= WRITE;
                            addr_cnt <= cmd_addr;
                        end else begin
                            state    <= READ_ISSUE;
                            En       <= 1'b1;
                            RW       <= 1'b0;
                            Address  <= cmd_addr;
                            addr_cnt <= cmd_addr + ADDR_W'(1);
                        end
                    end
                end
                WRITE: begin
                    RW <= 1'b1;
                    if (wr_valid) begin
                        En       <= 1'b1;
                        Address  <= addr_cnt;
                        wr_q     <= wr_data;
                        addr_cnt <= addr_cnt + ADDR_W'(1);
                        beats    <= beats - (LEN_W+1)'(1);
                        if (last_beat) begin
                            state <= FINISH;
                        end
                    end else begin
                        En <= 1'b0;
                    end
                end
                READ_ISSUE: begin
                    state <= READ_WAIT;
                end
                READ_WAIT: begin
                    rd_data  <= Data;
                    rd_valid <= 1'b1;
                    beats    <= beats - (LEN_W+1)'(1);
                    if (last_beat) begin
                        state <= FINISH;
                        En    <= 1'b0;
                    end else begin
                        state    <= READ_ISSUE;
                        Address  <= addr_cnt;
                        addr_cnt <= addr_cnt + ADDR_W'(1);
                    end
                end
                FINISH: begin
                    En    <= 1'b0;
                    RW    <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    En    <= 1'b0;
                    RW    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter LEN_W, default 4, burst length field width (beats = cmd_len+1).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  high only in IDLE and not in reset.
REQ-008 cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-009 cmd_addr  input  ADDR_W  burst start address.
REQ-010 cmd_len  input  LEN_W  beats minus one.
REQ-011 wr_data  input  DATA_W  write beat payload.
REQ-012 wr_valid / wr_ready  input / output  1 each  write beat handshake.
REQ-013 rd_data  output  DATA_W  captured read beat.
REQ-014 rd_valid  output  1  one-cycle pulse per read beat; no backpressure.
REQ-015 done  output  1  one-cycle pulse at burst completion.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 Address  output  ADDR_W  RAM address, registered.
REQ-018 Data  inout  DATA_W  RAM data bus; driven only when En=1 and RW=1, else high-Z.
REQ-019 RW  output  1  RAM direction, 1 = write, 0 = read; registered.
REQ-020 En  output  1  RAM enable; registered.

Function
REQ-021 States: IDLE, WRITE, READ_ISSUE, READ_WAIT, FINISH.
REQ-022 IDLE: cmd_valid&cmd_ready at edge latches addr, beat count = cmd_len+1, direction; goes to WRITE or READ_ISSUE.
REQ-023 WRITE: wr_ready=1 while beats remain unaccepted; beat accepted at edge N drives En=1, RW=1, Address=current, Data=beat for cycle N..N+1; RAM captures at edge N+1.
REQ-024 WRITE stall: wr_valid=0 -> next cycle En=0, RW=1, Data high-Z, address and count hold.
REQ-025 Write throughput one beat per cycle; after final beat accepted wr_ready=0 and state -> FINISH.
REQ-026 READ_ISSUE: one cycle En=1, RW=0, Address=current; -> READ_WAIT.
REQ-027 READ_WAIT: En=1, RW=0 held one cycle; Data sampled into rd_data at its closing edge; rd_valid=1 the following cycle.
REQ-028 Read period two cycles per beat; after last beat -> FINISH, else READ_ISSUE with next address.
REQ-029 Address increments by 1 per beat modulo 2^ADDR_W (1023 -> 0 at default).
REQ-030 FINISH: En=0, RW=0, done=1 for exactly one cycle; -> IDLE.
REQ-031 cmd_valid outside IDLE is ignored; no queuing.
REQ-032 Beat count 1..2^LEN_W (1..16); cmd_len=0 is a single beat.
REQ-033 Data never driven in the same cycle the RAM is selected for read; RW falls 1->0 only with En=0 in that cycle.

Reset
REQ-034 rst=1 at an edge forces IDLE; next cycle En=0, RW=0, Address=0, Data high-Z, wr_ready=0, rd_valid=0, done=0, busy=0, rd_data=0.
REQ-035 cmd_ready=0 while rst=1.
REQ-036 Reset mid-burst aborts: no further RAM enables, remaining beats discarded, no done pulse; words already written stay written.

Verification
REQ-037 Reset: assert rst 2 cycles -> all outputs per REQ-034, Data high-Z.
REQ-038 Single write 0xF0 to addr 3, then single read addr 3 -> rd_data=0xF0, rd_valid one cycle, done once per command.
REQ-039 Write burst addr 1022, cmd_len=3, data 0xAA,0x55,0x0F,0xF0 -> Address sequence 1022,1023,0,1; read-back burst returns same bytes in order.
REQ-040 Write burst with wr_valid low 2 cycles mid-burst -> En=0 those cycles, no extra or lost beats, done after 4th beat.
REQ-041 rst asserted after 2nd beat of 4-beat write -> En=0 next cycle, no done; reads of addrs 0,1 return new data, addrs 2,3 old.
REQ-042 cmd_valid pulsed while busy -> ignored; cmd_ready=0; current burst unaffected.
